morph_window_filter: RTL and testbench
======================================

Name: morph_window_filter

Overview:
- Parametrised binary morphology engine for the 1-bit mask path, driven by the video timing counters.
- Builds a WIN x WIN window from WIN-1 internal line buffers plus the live pixel.
- Per frame, applies a runtime-selected operator: dilate, erode, median, or centre pass-through.
- Sits between the threshold/segmentation stage and the downstream blob/overlay logic; generalises the fixed-window dilate stage.

Parameters:
- IMG_W, 640, active pixels per line; line-buffer depth; 2R+1 <= IMG_W <= 4095.
- IMG_H, 480, active lines per frame; 2R+1 <= IMG_H <= 4095.
- WIN, 3, window edge; odd, 3..7. R = (WIN-1)/2.
- BORDER_VAL, 0, pix_o value wherever the full window is not available.

Ports:
- PCLK  in  1  pixel clock; all logic on rising edge.
- RST  in  1  asynchronous, active-high reset.
- VtcHCnt  in  12  column of the current input pixel.
- VtcVCnt  in  12  line of the current input pixel.
- de_i  in  1  input pixel valid.
- pix_i  in  1  input mask pixel.
- mode_i  in  2  operator select: 00 dilate, 01 erode, 10 median, 11 pass-through.
- de_o  out  1  output pixel valid.
- pix_o  out  1  filtered pixel.
- mode_o  out  2  operator currently in effect; diagnostic.

Behaviour:
- Reset: asynchronous, active-high. de_o=0, pix_o=BORDER_VAL, mode_o=00, column shift registers cleared, row-rotation pointer=0. Line-buffer RAM is not reset; stale contents are masked by the gating rule below.
- Accepted pixel: de_i=1 with x=VtcHCnt<IMG_W and y=VtcVCnt<IMG_H.
  - pix_i is written to the line buffer selected by the rotation pointer, at address x.
  - All WIN column shift registers advance by one.
- Rotation pointer: advances (mod WIN-1) on the accepted pixel with x=IMG_W-1. Forced to 0 on the accepted pixel with x=0, y=0.
- Window at input (x,y): rows y-2R..y, columns x-2R..x.
  - Row y comes from pix_i plus the row-0 shift register.
  - Older rows come from the line buffers, ordered by age via the rotation pointer.
  - The result is the centred result for pixel (x-R, y-R).
- Gating: if x<2R or y<2R, pix_o=BORDER_VAL, regardless of mode. No partial windows and no zero padding.
- Operators, on N=WIN*WIN window bits:
  - dilate: pix_o=1 iff any bit is 1.
  - erode: pix_o=1 iff all bits are 1.
  - median: pix_o=1 iff popcount > N/2 (integer division; 3x3 threshold is 5 ones).
  - pass-through: pix_o = window centre bit, i.e. input pixel (x-R, y-R).
- Timing:
  - Latency is exactly 1 PCLK; pix_o/de_o are registered.
  - de_o = de_i delayed 1 cycle.
  - pix_o holds its last value when de_o=0.
- Mode latch: mode_i is sampled only on the accepted pixel at x=0, y=0; that pixel already uses the new mode. mode_o shows the latched value. Mid-frame changes on mode_i are ignored until the next frame start.
- Out-of-range pixel (de_i=1, x>=IMG_W or y>=IMG_H):
  - no buffer write, no shift, no pointer change;
  - de_o=1, pix_o=BORDER_VAL one cycle later.
- de_i=0: no state change except de_o<=0.
- Bottom R rows and right R columns of centres are never emitted; the output image is shifted by (R,R) relative to input coordinates.
- Reset mid-frame: outputs return to reset values immediately. The first frame after reset is valid from the next x=0, y=0 pixel; rows with y>=2R of that frame are correct.

Test Plan:
- 640x480, WIN=3, dilate, single 1 at (100,100), rest 0 -> pix_o=1 exactly at input coords x=100..102, y=100..102 (centres 99..101); 9 ones per frame, 1-cycle latency.
- WIN=3, erode, 5x5 block of 1s at (200..204, 50..54) -> 3x3 ones at centres (201..203, 51..53), i.e. input coords x=202..204, y=52..54; all else 0.
- WIN=5, median, 5x5 window with 13 ones -> pix_o=1; same window with 12 ones -> pix_o=0.
- Pass-through, random mask -> pix_o at input (x,y) equals pix_i of (x-1, y-1) for x,y>=2. With BORDER_VAL=1, all pixels with x<2 or y<2 read 1.
- Toggle mode_i from 00 to 01 at line 240 -> operator unchanged until the next frame. mode_o=01 from the first pixel (0,0) of the next frame.
- Assert RST at (320,240), release, restart at (0,0) -> de_o/pix_o reset immediately. No stale-window artefact in rows y>=2R of the restarted frame; pixels with out-of-range x=640 give de_o=1, pix_o=BORDER_VAL.

Source files
------------

// File: rtl/morph_window_filter_if.sv
// Pixel-stream bundle for morph_window_filter: video timing counters and mask
// pixel toward the filter, filtered mask pixel and active operator back out.
interface morph_window_filter_if;
  logic [11:0] VtcHCnt;
  logic [11:0] VtcVCnt;
  logic        de_i;
  logic        pix_i;
  logic [1:0]  mode_i;
  logic        de_o;
  logic        pix_o;
  logic [1:0]  mode_o;

  modport master (
    output VtcHCnt, VtcVCnt, de_i, pix_i, mode_i,
    input  de_o, pix_o, mode_o
  );

  modport slave (
    input  VtcHCnt, VtcVCnt, de_i, pix_i, mode_i,
    output de_o, pix_o, mode_o
  );
endinterface

// File: rtl/morph_window_filter.sv
// WIN x WIN binary morphology (dilate / erode / median / centre pass-through)
// on the 1-bit mask stream, built from WIN-1 rotating line buffers plus the live pixel.
module morph_window_filter #(
  parameter int   IMG_W      = 640,
  parameter int   IMG_H      = 480,
  parameter int   WIN        = 3,
  parameter logic BORDER_VAL = 1'b0
) (
  input logic                  PCLK,
  input logic                  RST,
  morph_window_filter_if.slave bus
);

  localparam int R   = (WIN - 1) / 2;
  localparam int NLB = WIN - 1;
  localparam int N   = WIN * WIN;
  localparam int AW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int PW  = (NLB > 1) ? $clog2(NLB) : 1;
  localparam int CW  = $clog2(N + 1);

  localparam logic [11:0] W_LIM  = 12'(IMG_W);
  localparam logic [11:0] H_LIM  = 12'(IMG_H);
  localparam logic [11:0] X_LAST = 12'(IMG_W - 1);
  localparam logic [11:0] EDGE   = 12'(2 * R);

  typedef enum logic [1:0] {
    OP_DILATE = 2'b00,
    OP_ERODE  = 2'b01,
    OP_MEDIAN = 2'b10,
    OP_PASS   = 2'b11
  } op_e;

  logic                    in_range;
  logic                    accept;
  logic                    frame_start;
  logic                    line_end;
  logic                    gated;
  logic [AW-1:0]           addr;
  logic [PW-1:0]           ptr_q, ptr_d, ptr_eff;
  op_e                     mode_q, mode_d, mode_eff;
  logic [WIN-1:0][WIN-2:0] sr_q, sr_d;
  logic [WIN-1:0]          col_bits;
  logic [WIN-1:0][WIN-1:0] win;
  logic [CW-1:0]           ones;
  logic                    any_one;
  logic                    all_ones;
  logic                    op_result;
  logic                    de_q, de_d;
  logic                    pix_q, pix_d;
  int                      rd_sel;

  logic lb_mem [NLB][IMG_W];

  // Row y-k lives in the buffer written k lines ago, so rows are ordered by
  // age relative to the pointer. The oldest row shares the buffer currently
  // being written and is read here before this cycle's write lands.
  always_comb begin
    in_range    = (bus.VtcHCnt < W_LIM) && (bus.VtcVCnt < H_LIM);
    accept      = bus.de_i && in_range;
    frame_start = accept && (bus.VtcHCnt == 12'd0) && (bus.VtcVCnt == 12'd0);
    line_end    = accept && (bus.VtcHCnt == X_LAST);
    gated       = (bus.VtcHCnt < EDGE) || (bus.VtcVCnt < EDGE);
    addr        = bus.VtcHCnt[AW-1:0];
    ptr_eff     = frame_start ? '0 : ptr_q;
    mode_eff    = frame_start ? op_e'(bus.mode_i) : mode_q;

    rd_sel      = 0;
    col_bits    = '0;
    col_bits[0] = bus.pix_i;
    for (int k = 1; k < WIN; k++) begin
      rd_sel      = (int'(ptr_eff) >= k) ? int'(ptr_eff) - k : int'(ptr_eff) + NLB - k;
      col_bits[k] = lb_mem[PW'(rd_sel)][addr];
    end
  end

  always_comb begin
    win = '0;
    for (int r = 0; r < WIN; r++) begin
      win[r][0] = col_bits[r];
      for (int c = 1; c < WIN; c++) begin
        win[r][c] = sr_q[r][c-1];
      end
    end

    ones = '0;
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN; c++) begin
        ones = ones + CW'(win[r][c]);
      end
    end
    any_one  = |win;
    all_ones = &win;

    op_result = BORDER_VAL;
    case (mode_eff)
      OP_DILATE: op_result = any_one;
      OP_ERODE:  op_result = all_ones;
      OP_MEDIAN: op_result = (ones > CW'(N / 2));
      OP_PASS:   op_result = win[R][R];
    endcase
  end

  // Out-of-range pixels still produce a border pixel but leave every piece of
  // window state untouched; idle cycles only clear the valid flag.
  always_comb begin
    de_d   = bus.de_i;
    pix_d  = pix_q;
    ptr_d  = ptr_q;
    mode_d = mode_eff;
    sr_d   = sr_q;

    if (accept) begin
      pix_d = gated ? BORDER_VAL : op_result;
      ptr_d = ptr_eff;
      if (line_end) begin
        ptr_d = (ptr_eff == PW'(NLB - 1)) ? '0 : ptr_eff + PW'(1);
      end
      for (int r = 0; r < WIN; r++) begin
        sr_d[r] = {sr_q[r][WIN-3:0], col_bits[r]};
      end
    end else if (bus.de_i) begin
      pix_d = BORDER_VAL;
    end
  end

  always_ff @(posedge PCLK or posedge RST) begin
    if (RST) begin
      de_q   <= 1'b0;
      pix_q  <= BORDER_VAL;
      mode_q <= OP_DILATE;
      ptr_q  <= '0;
      sr_q   <= '0;
    end else begin
      de_q   <= de_d;
      pix_q  <= pix_d;
      mode_q <= mode_d;
      ptr_q  <= ptr_d;
      sr_q   <= sr_d;
    end
  end

  // Line storage is plain RAM; stale contents only ever reach gated rows.
  always_ff @(posedge PCLK) begin
    if (accept) begin
      lb_mem[ptr_eff][addr] <= bus.pix_i;
    end
  end

  assign bus.de_o   = de_q;
  assign bus.pix_o  = pix_q;
  assign bus.mode_o = mode_q;

endmodule

// File: tb/tb_morph_window_filter.sv
// Self-checking bench for morph_window_filter: three instances (3x3 border 0,
// 3x3 border 1, 5x5 border 0) share one stimulus stream on a small image.
module tb_morph_window_filter;

  localparam int W = 16;
  localparam int H = 12;

  typedef struct packed {
    logic        de;
    logic        p3;
    logic        p3b;
    logic        p5;
    logic [1:0]  m;
    logic [11:0] x;
    logic [11:0] y;
  } rec_t;

  logic        PCLK;
  logic        RST;
  logic [11:0] hcnt;
  logic [11:0] vcnt;
  logic        de_s;
  logic        pix_s;
  logic [1:0]  mode_s;

  rec_t exp_q[$];
  rec_t obs_q[$];
  int   checks   = 0;
  int   failures = 0;

  logic img [H][W];
  logic pat [H][W];
  logic h3, h3b, h5;
  logic [1:0] m_mode;

  morph_window_filter_if bus3 ();
  morph_window_filter_if bus3b ();
  morph_window_filter_if bus5 ();

  assign bus3.VtcHCnt  = hcnt;
  assign bus3.VtcVCnt  = vcnt;
  assign bus3.de_i     = de_s;
  assign bus3.pix_i    = pix_s;
  assign bus3.mode_i   = mode_s;
  assign bus3b.VtcHCnt = hcnt;
  assign bus3b.VtcVCnt = vcnt;
  assign bus3b.de_i    = de_s;
  assign bus3b.pix_i   = pix_s;
  assign bus3b.mode_i  = mode_s;
  assign bus5.VtcHCnt  = hcnt;
  assign bus5.VtcVCnt  = vcnt;
  assign bus5.de_i     = de_s;
  assign bus5.pix_i    = pix_s;
  assign bus5.mode_i   = mode_s;

  morph_window_filter #(.IMG_W(W), .IMG_H(H), .WIN(3), .BORDER_VAL(1'b0)) dut3 (
    .PCLK(PCLK), .RST(RST), .bus(bus3)
  );
  morph_window_filter #(.IMG_W(W), .IMG_H(H), .WIN(3), .BORDER_VAL(1'b1)) dut3b (
    .PCLK(PCLK), .RST(RST), .bus(bus3b)
  );
  morph_window_filter #(.IMG_W(W), .IMG_H(H), .WIN(5), .BORDER_VAL(1'b0)) dut5 (
    .PCLK(PCLK), .RST(RST), .bus(bus5)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  // Reference: full-frame 2D window straight from the stored image.
  function automatic logic model_op(int w, logic b, int x, int y, logic [1:0] md);
    int r;
    int cnt;
    r   = (w - 1) / 2;
    cnt = 0;
    if (x < 2 * r || y < 2 * r) return b;
    for (int i = y - 2 * r; i <= y; i++) begin
      for (int j = x - 2 * r; j <= x; j++) begin
        cnt += int'(img[i][j]);
      end
    end
    case (md)
      2'b00:   return (cnt > 0);
      2'b01:   return (cnt == w * w);
      2'b10:   return (cnt > (w * w) / 2);
      default: return img[y-r][x-r];
    endcase
  endfunction

  task automatic model_reset();
    h3     = 1'b0;
    h3b    = 1'b1;
    h5     = 1'b0;
    m_mode = 2'b00;
  endtask

  task automatic send(input int x, input int y, input logic de, input logic pix,
                      input logic [1:0] mode);
    rec_t e;
    rec_t o;
    logic acc;
    hcnt   = 12'(x);
    vcnt   = 12'(y);
    de_s   = de;
    pix_s  = pix;
    mode_s = mode;
    acc    = de && (x < W) && (y < H);
    if (acc && x == 0 && y == 0) m_mode = mode;
    if (acc) begin
      img[y][x] = pix;
      h3  = model_op(3, 1'b0, x, y, m_mode);
      h3b = model_op(3, 1'b1, x, y, m_mode);
      h5  = model_op(5, 1'b0, x, y, m_mode);
    end else if (de) begin
      h3  = 1'b0;
      h3b = 1'b1;
      h5  = 1'b0;
    end
    e.de = de;  e.p3 = h3;  e.p3b = h3b;  e.p5 = h5;  e.m = m_mode;
    e.x  = 12'(x);  e.y = 12'(y);
    exp_q.push_back(e);
    @(posedge PCLK);
    #1;
    o.de = bus3.de_o;  o.p3 = bus3.pix_o;  o.p3b = bus3b.pix_o;  o.p5 = bus5.pix_o;
    o.m  = bus3.mode_o;  o.x = e.x;  o.y = e.y;
    obs_q.push_back(o);
  endtask

  // Raster frame from pat[][], one out-of-range column and one idle cycle per
  // line, then an out-of-range row; optionally abandoned before (stop_x, stop_y).
  task automatic drive_frame(input logic [1:0] mode_a, input logic [1:0] mode_b,
                             input int switch_line, input int stop_x, input int stop_y);
    bit stop;
    logic [1:0] md;
    stop = 1'b0;
    md   = mode_a;
    for (int y = 0; y < H; y++) begin
      md = (y >= switch_line) ? mode_b : mode_a;
      for (int x = 0; x < W; x++) begin
        if (y == stop_y && x == stop_x) stop = 1'b1;
        if (!stop) send(x, y, 1'b1, pat[y][x], md);
      end
      if (!stop) begin
        send(W, y, 1'b1, 1'b1, md);
        send(0, y, 1'b0, 1'b1, md);
      end
    end
    if (!stop) begin
      send(0, H, 1'b1, 1'b1, md);
      send(0, 0, 1'b0, 1'b0, md);
    end
  endtask

  task automatic fill_pat(input int density_pct);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        pat[y][x] = ($urandom_range(0, 99) < density_pct);
  endtask

  task automatic clear_pat();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        pat[y][x] = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    hcnt = '0;  vcnt = '0;  de_s = 1'b0;  pix_s = 1'b0;  mode_s = 2'b00;
    model_reset();
    repeat (2) @(posedge PCLK);
    #1;
    checks++;
    if ({bus3.de_o, bus3b.de_o, bus5.de_o} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL reset_de got=%b exp=000", {bus3.de_o, bus3b.de_o, bus5.de_o});
    end
    checks++;
    if ({bus3.pix_o, bus3b.pix_o, bus5.pix_o} !== 3'b010) begin
      failures++;
      $display("[TB] FAIL reset_pix got=%b exp=010", {bus3.pix_o, bus3b.pix_o, bus5.pix_o});
    end
    checks++;
    if ({bus3.mode_o, bus5.mode_o} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_mode got=%b exp=0000", {bus3.mode_o, bus5.mode_o});
    end
    RST = 1'b0;
  endtask

  task automatic test_dilate();
    rec_t e, o;
    int ones, stray;
    ones = 0;  stray = 0;
    clear_pat();
    pat[5][5] = 1'b1;
    drive_frame(2'b00, 2'b00, H + 1, -1, -1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();  o = obs_q.pop_front();
      checks++;
      if (o[29:24] !== e[29:24]) begin
        failures++;
        $display("[TB] FAIL dilate x=%0d y=%0d got=%b exp=%b", e.x, e.y, o[29:24], e[29:24]);
      end
      if (e.de && e.x < W && e.y < H && o.p3 === 1'b1) begin
        ones++;
        if (!(e.x >= 5 && e.x <= 7 && e.y >= 5 && e.y <= 7)) stray++;
      end
    end
    checks++;
    if (ones != 9) begin
      failures++;
      $display("[TB] FAIL dilate_count got=%0d exp=9", ones);
    end
    checks++;
    if (stray != 0) begin
      failures++;
      $display("[TB] FAIL dilate_place stray=%0d exp=0", stray);
    end
  endtask

  task automatic test_erode();
    rec_t e, o;
    int ones, stray;
    ones = 0;  stray = 0;
    clear_pat();
    for (int y = 3; y <= 7; y++)
      for (int x = 4; x <= 8; x++)
        pat[y][x] = 1'b1;
    drive_frame(2'b01, 2'b01, H + 1, -1, -1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();  o = obs_q.pop_front();
      checks++;
      if (o[29:24] !== e[29:24]) begin
        failures++;
        $display("[TB] FAIL erode x=%0d y=%0d got=%b exp=%b", e.x, e.y, o[29:24], e[29:24]);
      end
      if (e.de && e.x < W && e.y < H && o.p3 === 1'b1) begin
        ones++;
        if (!(e.x >= 6 && e.x <= 8 && e.y >= 5 && e.y <= 7)) stray++;
      end
    end
    checks++;
    if (ones != 9 || stray != 0) begin
      failures++;
      $display("[TB] FAIL erode_block got ones=%0d stray=%0d exp ones=9 stray=0", ones, stray);
    end
  endtask

  task automatic test_median();
    rec_t e, o;
    int k;
    for (int n = 13; n >= 12; n--) begin
      clear_pat();
      k = 0;
      for (int y = 3; y <= 7; y++)
        for (int x = 5; x <= 9; x++) begin
          pat[y][x] = (k < n);
          k++;
        end
      drive_frame(2'b10, 2'b10, H + 1, -1, -1);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();  o = obs_q.pop_front();
        checks++;
        if (o[29:24] !== e[29:24]) begin
          failures++;
          $display("[TB] FAIL median x=%0d y=%0d got=%b exp=%b", e.x, e.y, o[29:24], e[29:24]);
        end
        if (e.de && e.x == 9 && e.y == 7) begin
          checks++;
          if (o.p5 !== (n == 13)) begin
            failures++;
            $display("[TB] FAIL median5_ones%0d got=%b exp=%b", n, o.p5, (n == 13));
          end
        end
      end
    end
  endtask

  task automatic test_pass_border();
    rec_t e, o;
    logic want;
    fill_pat(50);
    drive_frame(2'b11, 2'b11, H + 1, -1, -1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();  o = obs_q.pop_front();
      checks++;
      if (o[29:24] !== e[29:24]) begin
        failures++;
        $display("[TB] FAIL pass x=%0d y=%0d got=%b exp=%b", e.x, e.y, o[29:24], e[29:24]);
      end
      if (e.de && e.x < W && e.y < H) begin
        want = (e.x < 2 || e.y < 2) ? 1'b1 : pat[int'(e.y) - 1][int'(e.x) - 1];
        checks++;
        if (o.p3b !== want) begin
          failures++;
          $display("[TB] FAIL pass_centre x=%0d y=%0d got=%b exp=%b", e.x, e.y, o.p3b, want);
        end
      end
    end
  endtask

  task automatic test_mode_switch();
    rec_t e, o;
    int bad;
    bit first;
    bad = 0;
    fill_pat(40);
    drive_frame(2'b00, 2'b01, 6, -1, -1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();  o = obs_q.pop_front();
      checks++;
      if (o[29:24] !== e[29:24]) begin
        failures++;
        $display("[TB] FAIL mode_hold x=%0d y=%0d got=%b exp=%b", e.x, e.y, o[29:24], e[29:24]);
      end
      if (o.m !== 2'b00) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("[TB] FAIL mode_midframe changed=%0d exp=0", bad);
    end
    fill_pat(80);
    drive_frame(2'b01, 2'b01, H + 1, -1, -1);
    first = 1'b1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();  o = obs_q.pop_front();
      checks++;
      if (o[29:24] !== e[29:24]) begin
        failures++;
        $display("[TB] FAIL mode_next x=%0d y=%0d got=%b exp=%b", e.x, e.y, o[29:24], e[29:24]);
      end
      if (first) begin
        checks++;
        if (o.m !== 2'b01) begin
          failures++;
          $display("[TB] FAIL mode_first_pixel got=%b exp=01", o.m);
        end
        first = 1'b0;
      end
    end
  endtask

  task automatic test_reset_midframe();
    rec_t e, o;
    fill_pat(60);
    drive_frame(2'b10, 2'b10, H + 1, 8, 6);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();  o = obs_q.pop_front();
      checks++;
      if (o[29:24] !== e[29:24]) begin
        failures++;
        $display("[TB] FAIL pre_reset x=%0d y=%0d got=%b exp=%b", e.x, e.y, o[29:24], e[29:24]);
      end
    end
    de_s = 1'b0;
    #2;
    RST = 1'b1;
    #1;
    checks++;
    if ({bus3.de_o, bus3.pix_o, bus3b.pix_o, bus5.pix_o} !== 4'b0010) begin
      failures++;
      $display("[TB] FAIL async_reset_out got=%b exp=0010",
               {bus3.de_o, bus3.pix_o, bus3b.pix_o, bus5.pix_o});
    end
    checks++;
    if (bus3.mode_o !== 2'b00) begin
      failures++;
      $display("[TB] FAIL async_reset_mode got=%b exp=00", bus3.mode_o);
    end
    model_reset();
    repeat (2) @(posedge PCLK);
    #1;
    RST = 1'b0;
    fill_pat(15);
    drive_frame(2'b00, 2'b00, H + 1, -1, -1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();  o = obs_q.pop_front();
      checks++;
      if (o[29:24] !== e[29:24]) begin
        failures++;
        $display("[TB] FAIL post_reset x=%0d y=%0d got=%b exp=%b", e.x, e.y, o[29:24], e[29:24]);
      end
      if (e.de && e.x == W) begin
        checks++;
        if ({o.de, o.p3, o.p3b, o.p5} !== 4'b1010) begin
          failures++;
          $display("[TB] FAIL oor_column y=%0d got=%b exp=1010", e.y, {o.de, o.p3, o.p3b, o.p5});
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    rec_t e, o;
    fill_pat(50);
    drive_frame(2'b11, 2'b11, H + 1, 3, 5);
    fill_pat(20);
    drive_frame(2'b00, 2'b00, H + 1, -1, -1);
    fill_pat(50);
    drive_frame(2'b10, 2'b10, H + 1, -1, -1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();  o = obs_q.pop_front();
      checks++;
      if (o[29:24] !== e[29:24]) begin
        failures++;
        $display("[TB] FAIL back_to_back x=%0d y=%0d got=%b exp=%b", e.x, e.y, o[29:24], e[29:24]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_dilate();
    test_erode();
    test_median();
    test_pass_border();
    test_mode_switch();
    test_reset_midframe();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
